// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-file widths, default control width
// and the bit positions of the packed control fields carried between stages.
package pipe_pkg;

  localparam int unsigned RegDataWidth = 32;
  localparam int unsigned RegAddrWidth = 5;

  localparam int unsigned DefCtrlWidth = 8;

  localparam int unsigned CTRL_WRITEREG = 0;
  localparam int unsigned CTRL_MEMORALU = 1;
  localparam int unsigned CTRL_WRITEMEM = 2;
  localparam int unsigned CTRL_WE_HI    = 3;
  localparam int unsigned CTRL_WE_LO    = 4;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage bus for pipe_stage_reg: upstream entry, stall/flush
// controls, and the downstream view of the last slot.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegDataWidth,
  parameter int unsigned CTRL_WIDTH = DefCtrlWidth,
  parameter int unsigned DEPTH      = 1
) ();

  logic                          is_hold;
  logic                          flush;
  logic                          valid_in;
  logic [CTRL_WIDTH-1:0]         ctrl_in;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          in_ready;
  logic                          valid_out;
  logic [CTRL_WIDTH-1:0]         ctrl_out;
  logic [DATA_WIDTH-1:0]         data_out;
  logic [$clog2(DEPTH+1)-1:0]    occupancy;

  // Pipeline context driving the register.
  modport master (
    output is_hold, flush, valid_in, ctrl_in, data_in,
    input  in_ready, valid_out, ctrl_out, data_out, occupancy
  );

  // The pipeline register itself.
  modport slave (
    input  is_hold, flush, valid_in, ctrl_in, data_in,
    output in_ready, valid_out, ctrl_out, data_out, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline slot: valid bit, control bits and payload. Bubbles carry
// cleared control; flush kills valid/ctrl but leaves the payload alone.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegDataWidth,
  parameter int unsigned CTRL_WIDTH = DefCtrlWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  src_valid,
  input  logic [CTRL_WIDTH-1:0] src_ctrl,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  valid,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  // Slot state: flush beats enable; an enabled slot loads its source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (en) begin
      valid <= src_valid;
      ctrl  <= src_valid ? src_ctrl : '0;
      data  <= src_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots of valid/ctrl/data
// with stall and flush. Define PIPE_BUBBLE_COLLAPSE_EN to let entries advance
// into empty downstream slots while stalled; otherwise a stall freezes all.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegDataWidth,
  parameter int unsigned CTRL_WIDTH = DefCtrlWidth,
  parameter int unsigned DEPTH      = 1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  localparam int unsigned OccWidth = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      en;
  logic [DEPTH-1:0]      slot_valid;
  logic [DEPTH-1:0]      src_valid;
  logic [CTRL_WIDTH-1:0] slot_ctrl [DEPTH];
  logic [CTRL_WIDTH-1:0] src_ctrl  [DEPTH];
  logic [DATA_WIDTH-1:0] slot_data [DEPTH];
  logic [DATA_WIDTH-1:0] src_data  [DEPTH];
  logic [OccWidth-1:0]   occ;
  logic                  any_empty;

  // Slot chain: slot 0 takes the upstream entry, slot i takes slot i-1.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign src_valid[i] = bus.valid_in;
      assign src_ctrl[i]  = bus.ctrl_in;
      assign src_data[i]  = bus.data_in;
    end else begin : g_body
      assign src_valid[i] = slot_valid[i-1];
      assign src_ctrl[i]  = slot_ctrl[i-1];
      assign src_data[i]  = slot_data[i-1];
    end

    pipe_stage_slot #(
      .DATA_WIDTH(DATA_WIDTH),
      .CTRL_WIDTH(CTRL_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .flush    (bus.flush),
      .src_valid(src_valid[i]),
      .src_ctrl (src_ctrl[i]),
      .src_data (src_data[i]),
      .valid    (slot_valid[i]),
      .ctrl     (slot_ctrl[i]),
      .data     (slot_data[i])
    );
  end

  // Slot enables: global freeze on stall, or per-slot advance into holes.
  always_comb begin
    en        = '0;
    any_empty = 1'b0;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
    // The recursive rule en[i] = !valid[i] || en[i+1] unrolls to "not held,
    // or some slot at or downstream of i is empty"; a running OR from the
    // output side gives that without a combinational chain through en.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      any_empty           = any_empty | ~slot_valid[DEPTH-1-k];
      en[DEPTH-1-k]       = ~bus.is_hold | any_empty;
    end
`else
    en = {DEPTH{~bus.is_hold}};
`endif
  end

  // Occupancy: popcount of the slot valid bits.
  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occ = occ + OccWidth'(slot_valid[k]);
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.valid_out = slot_valid[DEPTH-1];
  assign bus.ctrl_out  = slot_ctrl[DEPTH-1];
  assign bus.data_out  = slot_data[DEPTH-1];
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DEPTH=2 and DEPTH=3 instances driven in lockstep
// and compared every cycle against an array-based reference model. Honours
// PIPE_BUBBLE_COLLAPSE_EN in the same way as the design.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .DEPTH(2)) if2 ();
  pipe_stage_reg_if #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .DEPTH(3)) if3 ();

  pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );
  pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: index 0 is the DEPTH=2 instance, index 1 the DEPTH=3.
  int          dep [2] = '{2, 3};
  bit          m_v [2][3];
  logic [7:0]  m_c [2][3];
  logic [31:0] m_d [2][3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++) begin
        m_v[k][i] = 1'b0; m_c[k][i] = '0; m_d[k][i] = '0;
      end
  endtask

  // Which slots may load this edge, straight from the stall rules.
  task automatic model_en(input int k, input bit hold, output bit en [3]);
    int dd = dep[k];
    for (int i = 0; i < 3; i++) en[i] = !hold;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
    en[dd-1] = !hold || !m_v[k][dd-1];
    for (int i = dd - 2; i >= 0; i--) en[i] = !m_v[k][i] || en[i+1];
`endif
  endtask

  function automatic int model_occ(input int k);
    int n = 0;
    for (int i = 0; i < dep[k]; i++) n += int'(m_v[k][i]);
    return n;
  endfunction

  task automatic model_step(input int k, input bit hold, input bit fl, input bit v,
                            input logic [7:0] c, input logic [31:0] d);
    bit en [3];
    bit ov [3]; logic [7:0] oc [3]; logic [31:0] od [3];
    bit sv; logic [7:0] sc; logic [31:0] sd;
    model_en(k, hold, en);
    for (int i = 0; i < 3; i++) begin ov[i] = m_v[k][i]; oc[i] = m_c[k][i]; od[i] = m_d[k][i]; end
    for (int i = 0; i < dep[k]; i++) begin
      if (fl) begin
        m_v[k][i] = 1'b0; m_c[k][i] = '0;
      end else if (en[i]) begin
        if (i == 0) begin sv = v; sc = c; sd = d; end
        else begin sv = ov[i-1]; sc = oc[i-1]; sd = od[i-1]; end
        m_v[k][i] = sv;
        m_c[k][i] = sv ? sc : 8'h00;
        m_d[k][i] = sd;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("d2_valid_out", 32'(if2.valid_out), 32'(m_v[0][1]));
    check_eq("d2_ctrl_out",  32'(if2.ctrl_out),  32'(m_c[0][1]));
    check_eq("d2_data_out",  if2.data_out,       m_d[0][1]);
    check_eq("d2_occupancy", 32'(if2.occupancy), 32'(model_occ(0)));
    check_eq("d3_valid_out", 32'(if3.valid_out), 32'(m_v[1][2]));
    check_eq("d3_ctrl_out",  32'(if3.ctrl_out),  32'(m_c[1][2]));
    check_eq("d3_data_out",  if3.data_out,       m_d[1][2]);
    check_eq("d3_occupancy", 32'(if3.occupancy), 32'(model_occ(1)));
  endtask

  // One clock: drive at the falling edge, check ready, clock, check state.
  task automatic cycle(input bit hold, input bit fl, input bit v,
                       input logic [7:0] c, input logic [31:0] d);
    bit en [3];
    @(negedge clk);
    if2.is_hold = hold; if2.flush = fl; if2.valid_in = v; if2.ctrl_in = c; if2.data_in = d;
    if3.is_hold = hold; if3.flush = fl; if3.valid_in = v; if3.ctrl_in = c; if3.data_in = d;
    #1;
    model_en(0, hold, en);
    check_eq("d2_in_ready", 32'(if2.in_ready), 32'(en[0]));
    model_en(1, hold, en);
    check_eq("d3_in_ready", 32'(if3.in_ready), 32'(en[0]));
    @(posedge clk);
    model_step(0, hold, fl, v, c, d);
    model_step(1, hold, fl, v, c, d);
    #1;
    check_outputs();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if2.is_hold = 0; if2.flush = 0; if2.valid_in = 0; if2.ctrl_in = '0; if2.data_in = '0;
    if3.is_hold = 0; if3.flush = 0; if3.valid_in = 0; if3.ctrl_in = '0; if3.data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Fill DEPTH=3, then async reset mid-cycle.
    cycle(0, 0, 1, 8'h05, 32'h1);
    cycle(0, 0, 1, 8'h05, 32'h2);
    cycle(0, 0, 1, 8'h05, 32'h3);
    check_eq("rst_pre_occ", 32'(if3.occupancy), 32'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_async_valid", 32'(if3.valid_out), 32'd0);
    check_eq("rst_async_ctrl",  32'(if3.ctrl_out),  32'd0);
    check_eq("rst_async_occ",   32'(if3.occupancy), 32'd0);
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(0, 0, 1, 8'h05, 32'hA5A5A5A5);
    cycle(0, 0, 0, 8'h00, 32'h0);
    cycle(0, 0, 0, 8'h00, 32'h0);
    check_eq("rst_resume_data",  if3.data_out, 32'hA5A5A5A5);
    check_eq("rst_resume_valid", 32'(if3.valid_out), 32'd1);

    // Streaming through DEPTH=2.
    cycle(0, 0, 1, 8'h05, 32'h11);
    cycle(0, 0, 1, 8'h05, 32'h22);
    check_eq("stream_0x11", if2.data_out, 32'h11);
    check_eq("stream_occ",  32'(if2.occupancy), 32'd2);
    cycle(0, 0, 1, 8'h05, 32'h33);
    check_eq("stream_0x22", if2.data_out, 32'h22);
    check_eq("stream_ctrl", 32'(if2.ctrl_out), 32'h05);
    cycle(0, 0, 0, 8'h00, 32'h0);
    check_eq("stream_0x33", if2.data_out, 32'h33);

    // Stall with two valid entries.
    cycle(0, 0, 1, 8'h05, 32'h44);
    cycle(0, 0, 1, 8'h05, 32'h55);
    for (int n = 0; n < 4; n++) begin
      cycle(1, 0, 1, 8'h05, 32'h66);
      check_eq("hold_data",  if2.data_out, 32'h44);
      check_eq("hold_occ",   32'(if2.occupancy), 32'd2);
      check_eq("hold_ready", 32'(if2.in_ready), 32'd0);
    end
    cycle(0, 0, 1, 8'h05, 32'h66);
    check_eq("hold_resume_55", if2.data_out, 32'h55);
    cycle(0, 0, 1, 8'h05, 32'h77);
    check_eq("hold_resume_66", if2.data_out, 32'h66);

    // Flush beats hold and drops the presented entry.
    cycle(1, 1, 1, 8'h05, 32'h99);
    check_eq("flush_occ",  32'(if2.occupancy), 32'd0);
    check_eq("flush_ctrl", 32'(if2.ctrl_out), 32'd0);
    cycle(0, 0, 0, 8'h00, 32'h0);
    cycle(0, 0, 0, 8'h00, 32'h0);

    // Bubble presented with ctrl all-ones must arrive with ctrl cleared.
    cycle(0, 0, 1, 8'hFF, 32'hAA);
    cycle(0, 0, 0, 8'hFF, 32'h1234);
    cycle(0, 0, 1, 8'h03, 32'h1);
    check_eq("bubble_valid", 32'(if2.valid_out), 32'd0);
    check_eq("bubble_ctrl",  32'(if2.ctrl_out), 32'd0);
    check_eq("bubble_data",  if2.data_out, 32'h1234);

    // DEPTH=3 with only the output slot valid, then stall with new input.
    cycle(0, 1, 0, 8'h00, 32'h0);
    cycle(0, 0, 1, 8'h05, 32'hE0);
    cycle(0, 0, 0, 8'h00, 32'h0);
    cycle(0, 0, 0, 8'h00, 32'h0);
    cycle(1, 0, 1, 8'h05, 32'hA1);
    cycle(1, 0, 1, 8'h05, 32'hB2);
    cycle(1, 0, 1, 8'h05, 32'hC3);
`ifdef PIPE_BUBBLE_COLLAPSE_EN
    check_eq("collapse_occ",   32'(if3.occupancy), 32'd3);
    check_eq("collapse_ready", 32'(if3.in_ready), 32'd0);
    check_eq("collapse_valid", 32'(if3.valid_out), 32'd1);
    check_eq("collapse_data",  if3.data_out, 32'hE0);
`else
    check_eq("freeze_occ",  32'(if3.occupancy), 32'd1);
    check_eq("freeze_data", if3.data_out, 32'hE0);
`endif
    repeat (3) cycle(0, 0, 0, 8'h00, 32'h0);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the CPU pipeline, the successor to the fixed per-field stage latches.
- Carries one payload word and one control-bit vector through DEPTH register slots, with a valid bit per slot.
- Supports stall (is_hold) and flush (bubble insertion), and optionally collapses bubbles while stalled.
- Instantiated between pipeline stages, e.g. EX->MEM and MEM->WB; DEPTH>1 covers multi-cycle paths.

Parameters:
- DATA_WIDTH, 32, payload width in bits (data, hi/lo, rdata_2 and target packed by the instantiator).
- CTRL_WIDTH, 8, control-bit width (WriteReg, MemOrAlu, WriteMem, we_hi, we_lo, ...); these bits are cleared on bubbles.
- DEPTH, 1, number of register slots; must be 1 or more.

Ports:
- clk, input, 1, pipeline clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- is_hold, input, 1, stall request from downstream.
- flush, input, 1, kill all in-flight entries.
- valid_in, input, 1, upstream entry is valid.
- ctrl_in, input, CTRL_WIDTH, upstream control bits.
- data_in, input, DATA_WIDTH, upstream payload.
- in_ready, output, 1, slot 0 accepts this cycle (upstream must hold its value when low).
- valid_out, output, 1, last slot is valid.
- ctrl_out, output, CTRL_WIDTH, last slot control; always 0 when valid_out=0.
- data_out, output, DATA_WIDTH, last slot payload.
- occupancy, output, $clog2(DEPTH+1), count of valid slots.

Behaviour:
- Reset: rst is asynchronous and active-high. While asserted, all valid bits, ctrl and data registers are 0, so valid_out=0, ctrl_out=0, data_out=0 and occupancy=0. Deasserting rst mid-operation resumes from the empty state.
- Slots are numbered 0 (input side) to DEPTH-1 (output side). Each slot holds valid[i], ctrl[i] and data[i]. Outputs are driven directly from slot DEPTH-1.
- Enables, base build:
  - en[i] = !is_hold for every slot.
  - in_ready = !is_hold.
- Enabled slot i loads from slot i-1, or from the inputs when i=0.
  - If the source is invalid, the slot loads a bubble: valid=0, ctrl=0, data copied unchanged.
  - A disabled slot retains all of its fields.
- Flush: flush has priority over is_hold and over load. On the edge, every valid[i] and ctrl[i] is cleared, including the entry being presented at slot 0. Data registers retain their contents.
- Simultaneous flush and valid_in: the input entry is discarded. in_ready still reflects the enable, but the entry is not captured.
- Latency: with no hold, an entry presented at edge N appears on the outputs after edge N+DEPTH-1 (DEPTH=1 means the output is visible one cycle after capture).
- occupancy: combinational popcount of the valid[] registers.
- Payload and ctrl are opaque; there is no arithmetic on them.

Optional Feature:
- Macro: PIPE_BUBBLE_COLLAPSE_EN.
- With the macro defined, enables become per-slot:
  - en[DEPTH-1] = !is_hold || !valid[DEPTH-1].
  - en[i] = !valid[i] || en[i+1], for i < DEPTH-1.
  - in_ready = en[0].
- Effect: while stalled, entries advance into empty downstream slots, so bubbles are squeezed out and new input is accepted until all slots are full. With DEPTH=1, the block accepts while held only if it is empty.
- Without the macro: global freeze as in the base rules.
- Flush behaviour is identical in both builds.

Decomposition:
- Shared package pipe_pkg:
  - width constants RegDataWidth and RegAddrWidth.
  - default CTRL_WIDTH.
  - packed control-field bit positions (CTRL_WRITEREG, CTRL_MEMORALU, CTRL_WRITEMEM, CTRL_WE_HI, CTRL_WE_LO).
- One sub-module, pipe_stage_slot: a single valid/ctrl/data slot with inputs en, flush and the source fields. pipe_stage_reg instantiates DEPTH of these in a generate loop and computes the en chain.

Test Plan:
- Reset: DEPTH=3; assert rst mid-stream with 3 valid entries -> immediately valid_out=0, ctrl_out=0, occupancy=0; after release, data 0xA5A5A5A5 emerges after 3 edges.
- Streaming, DEPTH=2: push 0x11, 0x22, 0x33 on consecutive cycles with ctrl=0x05 -> outputs appear in order starting at cycle 2; occupancy holds at 2 during the stream.
- Hold, base build: hold 4 cycles with 2 valid entries -> outputs and occupancy frozen, in_ready=0; the stream resumes without loss or duplication.
- Flush with hold: flush and is_hold both high with valid_in=1 -> next cycle occupancy=0 and ctrl_out=0x00; the input entry is dropped.
- Collapse build, DEPTH=3, slots {valid, empty, empty}: hold asserted with 2 inputs -> slots fill to 3, then in_ready=0, occupancy=3, valid_out stays 1 with the original entry.
- Bubble ctrl: valid_in=0 with ctrl_in=0xFF -> ctrl_out=0x00 when that slot reaches the output.
